// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and default width for the sequential divider
package divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - combinational (WIDTH+1)-bit trial subtractor for one restoring step
module div_trial_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           non_neg
);

  assign diff    = minuend - subtrahend;
  assign non_neg = ~diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Optional zero-divisor early exit and flag: DIV_ZERO_CHECK_EN.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] dq;    // dividend bits shift out the top while quotient bits shift in below
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted, diff, rem_next;
  logic [WIDTH-1:0] dq_next;
  logic             non_neg, accept, last_iter, zero_bypass;

  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_iter = (state == ST_RUN) && (count == '0);

`ifdef DIV_ZERO_CHECK_EN
  assign zero_bypass = (state == ST_RUN) && (dsr == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  assign shifted = (part_rem << 1) | {{WIDTH{1'b0}}, dq[WIDTH-1]};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .minuend    (shifted),
    .subtrahend ({1'b0, dsr}),
    .diff       (diff),
    .non_neg    (non_neg)
  );

  assign rem_next = non_neg ? diff : shifted;
  assign dq_next  = {dq[WIDTH-2:0], non_neg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (zero_bypass || count == '0) state_next = ST_DONE;
      ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_rem <= '0;
      dq       <= '0;
      dsr      <= '0;
      count    <= '0;
    end else if (accept) begin
      part_rem <= '0;
      dq       <= dividend;
      dsr      <= divisor;
      count    <= CW'(WIDTH - 1);
    end else if (state == ST_RUN) begin
      part_rem <= rem_next;
      dq       <= dq_next;
      count    <= count - CW'(1);
    end
  end

  // Results only move on entry to DONE, so they hold through IDLE and the next RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (zero_bypass) begin
      quotient  <= '1;
      remainder <= dq;
    end else if (last_iter) begin
      quotient  <= dq_next;
      remainder <= rem_next[WIDTH-1:0];
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dz_q <= 1'b0;
    else if (zero_bypass) dz_q <= 1'b1;
    else if (last_iter)   dz_q <= 1'b0;
  end
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;

  localparam int W = 8;
`ifdef DIV_ZERO_CHECK_EN
  localparam int   ZLAT = 1;
  localparam logic ZDZ  = 1'b1;
`else
  localparam int   ZLAT = W;
  localparam logic ZDZ  = 1'b0;
`endif

  logic         clk, rst_n, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output int lat);
    if (b == 0) begin
      q = {W{1'b1}}; r = a; dz = ZDZ; lat = ZLAT;
    end else begin
      q = W'(a / b); r = W'(a % b); dz = 1'b0; lat = W;
    end
  endfunction

  // Starts an op at the current negedge; returns with the bench sitting on the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at,
                        output int lat, output int busy_err);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat = 0; busy_err = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_err++;
      start = (lat == inject_at);
      if (start) begin dividend = 9; divisor = 3; end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
    else if (busy !== 1'b0) busy_err++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (quotient !== '0) begin fails++; $display("FAIL reset_quotient got %0d want 0", quotient); end
    tests++; if (remainder !== '0) begin fails++; $display("FAIL reset_remainder got %0d want 0", remainder); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, be;
    run_op(8'd100, 8'd7, -1, lat, be);
    tests++; if (lat !== W) begin fails++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    tests++; if (be !== 0) begin fails++; $display("FAIL basic_busy errors %0d want 0", be); end
    tests++; if (quotient !== 8'd14) begin fails++; $display("FAIL basic_quotient got %0d want 14", quotient); end
    tests++; if (remainder !== 8'd2) begin fails++; $display("FAIL basic_remainder got %0d want 2", remainder); end
    tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL basic_dz got %b want 0", div_by_zero); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b want 0", done); end
    repeat (3) @(negedge clk);
    tests++; if (quotient !== 8'd14 || remainder !== 8'd2)
      begin fails++; $display("FAIL basic_hold got %0d r %0d want 14 r 2", quotient, remainder); end
  endtask

  task automatic test_values;
    int lat, be;
    run_op(8'd255, 8'd1, -1, lat, be);
    tests++; if (quotient !== 8'd255 || remainder !== 8'd0 || lat !== W)
      begin fails++; $display("FAIL div_255_1 got %0d r %0d lat %0d want 255 r 0 lat %0d", quotient, remainder, lat, W); end
    @(negedge clk);
    run_op(8'd5, 8'd9, -1, lat, be);
    tests++; if (quotient !== 8'd0 || remainder !== 8'd5 || lat !== W)
      begin fails++; $display("FAIL div_5_9 got %0d r %0d lat %0d want 0 r 5 lat %0d", quotient, remainder, lat, W); end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int lat, be;
    run_op(8'd200, 8'd0, -1, lat, be);
    tests++; if (lat !== ZLAT) begin fails++; $display("FAIL dz_latency got %0d want %0d", lat, ZLAT); end
    tests++; if (be !== 0) begin fails++; $display("FAIL dz_busy errors %0d want 0", be); end
    tests++; if (quotient !== 8'd255 || remainder !== 8'd200)
      begin fails++; $display("FAIL dz_result got %0d r %0d want 255 r 200", quotient, remainder); end
    tests++; if (div_by_zero !== ZDZ) begin fails++; $display("FAIL dz_flag got %b want %b", div_by_zero, ZDZ); end
    repeat (2) @(negedge clk);
    tests++; if (div_by_zero !== ZDZ) begin fails++; $display("FAIL dz_flag_hold got %b want %b", div_by_zero, ZDZ); end
  endtask

  task automatic test_ignore_start;
    int lat, be;
    run_op(8'd100, 8'd7, 3, lat, be);
    tests++; if (lat !== W) begin fails++; $display("FAIL midrun_latency got %0d want %0d", lat, W); end
    tests++; if (quotient !== 8'd14 || remainder !== 8'd2)
      begin fails++; $display("FAIL midrun_result got %0d r %0d want 14 r 2", quotient, remainder); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || done !== 1'b0)
      begin fails++; $display("FAIL midrun_no_restart busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_back_to_back;
    int lat, be, c1;
    run_op(8'd100, 8'd7, -1, lat, be);
    c1 = cyc;
    run_op(8'd9, 8'd3, -1, lat, be);
    tests++; if (cyc - c1 !== W + 1) begin fails++; $display("FAIL b2b_gap got %0d want %0d", cyc - c1, W + 1); end
    tests++; if (quotient !== 8'd3 || remainder !== 8'd0)
      begin fails++; $display("FAIL b2b_result got %0d r %0d want 3 r 0", quotient, remainder); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat, be, seen;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0)
      begin fails++; $display("FAIL abort_outputs busy %b done %b q %0d r %0d dz %b want all 0",
                              busy, done, quotient, remainder, div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done === 1'b1) seen++; end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done saw %0d done cycles want 0", seen); end
    run_op(8'd50, 8'd6, -1, lat, be);
    tests++; if (quotient !== 8'd8 || remainder !== 8'd2 || lat !== W)
      begin fails++; $display("FAIL abort_next got %0d r %0d lat %0d want 8 r 2 lat %0d", quotient, remainder, lat, W); end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, eq, er;
    logic edz;
    int elat, lat, be;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(a, b, eq, er, edz, elat);
      run_op(a, b, -1, lat, be);
      tests++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edz || lat !== elat || be !== 0) begin
        fails++;
        $display("FAIL random_%0d %0d/%0d got q %0d r %0d dz %b lat %0d busyerr %0d want q %0d r %0d dz %b lat %0d",
                 i, a, b, quotient, remainder, div_by_zero, lat, be, eq, er, edz, elat);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
